// File: rtl/divider_seq_ctrl.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock through a shared subtractor_n.
// Optional abort input is enabled by defining DIVIDER_SEQ_ABORT_EN.

module subtractor_n #(
   parameter int w = 9
) (
   input  logic [w-1:0] a_i,
   input  logic [w-1:0] b_i,
   output logic [w-1:0] diff_o,
   output logic         borrow_o
);
   assign {borrow_o, diff_o} = {1'b0, a_i} - {1'b0, b_i};
endmodule

// state | meaning
// IDLE  | waiting for start_i; results and div0_o held
// CALC  | one restoring step per clock, nb_bit steps
// DONE  | single-cycle done_o pulse, results valid
module divider_seq_ctrl #(
   parameter int nb_bit = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [nb_bit-1:0] dividend_i,
   input  logic [nb_bit-1:0] divisor_i,
`ifdef DIVIDER_SEQ_ABORT_EN
   input  logic              abort_i,
`endif
   output logic              busy_o,
   output logic              done_o,
   output logic              div0_o,
   output logic [nb_bit-1:0] quotient_o,
   output logic [nb_bit-1:0] remainder_o
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state, state_next;
   logic [nb_bit-1:0] d_reg, d_next;
   logic [nb_bit-1:0] q_reg, q_next;
   logic [nb_bit:0]   r_reg, r_next;
   logic [nb_bit-1:0] cnt, cnt_next;
   logic [nb_bit-1:0] quo_reg, quo_next;
   logic [nb_bit-1:0] rem_reg, rem_next;
   logic              div0_reg, div0_next;

   logic [nb_bit:0]   trial_s;
   logic [nb_bit:0]   trial_diff;
   logic              trial_borrow;

   // R never exceeds D after a step, so its top bit is not needed to form the next trial.
   logic              r_top_unused;
   assign r_top_unused = r_reg[nb_bit];

   assign trial_s = {r_reg[nb_bit-1:0], q_reg[nb_bit-1]};

   subtractor_n #(.w(nb_bit + 1)) u_sub (
      .a_i      (trial_s),
      .b_i      ({1'b0, d_reg}),
      .diff_o   (trial_diff),
      .borrow_o (trial_borrow)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         d_reg    <= '0;
         q_reg    <= '0;
         r_reg    <= '0;
         cnt      <= '0;
         quo_reg  <= '0;
         rem_reg  <= '0;
         div0_reg <= 1'b0;
      end else begin
         state    <= state_next;
         d_reg    <= d_next;
         q_reg    <= q_next;
         r_reg    <= r_next;
         cnt      <= cnt_next;
         quo_reg  <= quo_next;
         rem_reg  <= rem_next;
         div0_reg <= div0_next;
      end
   end

   // The step counter is a thermometer code: all ones holds nb_bit steps and each
   // right shift removes one, so no decrementer competes with the shared subtractor.
   always_comb begin
      state_next = state;
      d_next     = d_reg;
      q_next     = q_reg;
      r_next     = r_reg;
      cnt_next   = cnt;
      quo_next   = quo_reg;
      rem_next   = rem_reg;
      div0_next  = div0_reg;
      case (state)
         IDLE: begin
            if (start_i) begin
               d_next    = divisor_i;
               q_next    = dividend_i;
               r_next    = '0;
               cnt_next  = '1;
               div0_next = 1'b0;
               if (divisor_i == '0) begin
                  state_next = DONE;
                  div0_next  = 1'b1;
                  quo_next   = '1;
                  rem_next   = dividend_i;
               end else begin
                  state_next = CALC;
               end
            end
         end
         CALC: begin
`ifdef DIVIDER_SEQ_ABORT_EN
            if (abort_i) begin
               state_next = IDLE;
            end else begin
`endif
               r_next   = trial_borrow ? trial_s : trial_diff;
               q_next   = {q_reg[nb_bit-2:0], ~trial_borrow};
               cnt_next = cnt >> 1;
               if (cnt_next == '0) begin
                  state_next = DONE;
                  quo_next   = q_next;
                  rem_next   = r_next[nb_bit-1:0];
               end
`ifdef DIVIDER_SEQ_ABORT_EN
            end
`endif
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy_o      = (state == CALC);
   assign done_o      = (state == DONE);
   assign div0_o      = div0_reg;
   assign quotient_o  = quo_reg;
   assign remainder_o = rem_reg;

endmodule

// File: doc/divider_seq_ctrl.md
Name: divider_seq_ctrl

Overview:
- Multi-cycle unsigned restoring divider controller built around one shared subtractor_n instance.
- Performs one trial subtraction per clock and computes quotient and remainder over nb_bit cycles.
- Provides the team's first sequenced use of the subtractor datapath. Sits between a register-file or host interface and the arithmetic unit.

Parameters:
- nb_bit, 8, operand width in bits; must be >= 2. The internal subtractor_n is instantiated with nb_bit+1.

Ports:
- clk_i  input  1  clock, all logic on rising edge
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  request a division; sampled only in IDLE
- dividend_i  input  nb_bit  dividend, captured on accepted start
- divisor_i  input  nb_bit  divisor, captured on accepted start
- busy_o  output  1  high from the cycle after accept until done_o
- done_o  output  1  one-cycle pulse; results valid
- div0_o  output  1  divisor was zero; valid with done_o, held until next accept
- quotient_o  output  nb_bit  quotient, held until next accept
- remainder_o  output  nb_bit  remainder, held until next accept

Behaviour:
- Reset (rst_i high at a clock edge) forces the following, regardless of state, including mid-division:
  - state IDLE
  - busy_o=0, done_o=0, div0_o=0
  - quotient_o=0, remainder_o=0
  - internal counter=0
- States: IDLE, CALC, DONE.
- IDLE:
  - start_i=1 is accepted.
  - Latch divisor into D, dividend into Q, clear partial remainder R (nb_bit+1 bits), counter=nb_bit.
  - Next state is CALC. If divisor_i==0, next state is DONE with div0 set.
- CALC, each cycle:
  - Form S={R[nb_bit-1:0],Q[nb_bit-1]}.
  - The subtractor computes S-{1'b0,D}.
  - If borrow_o=0: R<=diff, Q<={Q[nb_bit-2:0],1}.
  - If borrow_o=1: R<=S, Q<={Q[nb_bit-2:0],0}.
  - Decrement counter. When the counter reaches 0 after the update, next state is DONE.
- DONE, for one cycle:
  - done_o=1, busy_o=0, next state IDLE.
  - quotient_o and remainder_o are registered on the DONE entry edge, so they are valid while done_o=1.
- Divide-by-zero result: quotient_o=all ones, remainder_o=dividend, div0_o=1.
- Latency, with accept at edge 0:
  - Normal case: busy_o=1 for edges 1..nb_bit; done_o=1 in the cycle after edge nb_bit+1 (nb_bit+1 clocks total).
  - div0 case: done_o=1 after edge 1 and busy_o never rises.
- Throughput: start_i is ignored in CALC and DONE; it is not queued. The earliest next accept is the cycle after DONE, i.e. when back in IDLE.
- Input stability: input changes during CALC have no effect, because operands are captured at accept.
- Output holding: results and div0_o keep their values through IDLE and change only at the next DONE entry. div0_o clears at the next accept.
- Subtraction: all subtraction goes through the single subtractor_n instance; there is no second adder/subtractor in the block.

Optional Feature:
- Macro DIVIDER_SEQ_ABORT_EN.
- When defined:
  - Adds input port abort_i (1 bit).
  - abort_i=1 in CALC returns the state to IDLE at the next edge; busy_o drops, no done_o pulse, result registers are unchanged.
  - abort_i in IDLE or DONE is ignored.
  - If abort_i and start_i are both high in IDLE, start wins.
- When undefined: no abort_i port, and a division always runs to completion unless rst_i is asserted.

Test Plan:
- nb_bit=8, dividend 100, divisor 7, start one cycle -> busy_o high 8 cycles; done_o pulse 9 cycles after accept; quotient_o=14, remainder_o=2, div0_o=0.
- Dividend 5, divisor 0 -> done_o the cycle after accept, busy_o stays 0; quotient_o=0xFF, remainder_o=5, div0_o=1. Next divide 9/3 -> div0_o=0, quotient_o=3, remainder_o=0.
- Edge operands:
  - 255/1 -> q=255, r=0
  - 3/200 -> q=0, r=3
  - 255/255 -> q=1, r=0
  - 254/255 -> q=0, r=254
- start_i held high continuously with 20/6 then operands changed mid-run -> results q=3 r=2; a new accept occurs only in IDLE after DONE; second result matches the operands present at that accept.
- rst_i asserted at cycle 4 of a 100/7 run -> next cycle all outputs 0, state IDLE; a new 50/5 start then completes with q=10, r=0.
- With DIVIDER_SEQ_ABORT_EN defined: abort_i at cycle 3 of 100/7 -> busy_o low next cycle, no done_o, outputs keep prior results. Without the macro the same bench compiles with abort_i removed.
